frame_bank_rotator: RTL and testbench
=====================================

// Module: frame_bank_rotator
// PURPOSE
// - N-bank (NUM_BANKS >= 3) frame-buffer bank manager for the DDR video path; parametrised successor to two-bank ping-pong.
// - Writer (CMOS side) and reader (display side) each own one DDR bank; completed frames are handed over at frame sync with no tearing.
// - Reports dropped (superseded) and repeated frames. Outputs feed {bank, offset} address generation and the load inputs of the FIFO controller.
// PARAMETERS
// NUM_BANKS    3   frame banks, legal 3..8; other values are an elaboration error
// BANK_W       3   bank index width, >= clog2(NUM_BANKS)
// SYNC_STAGES  2   synchroniser flops on vin_vs/vout_vs, legal 2..4
// VS_POL       1   1: frame boundary = rising edge of vs; 0: falling edge
// PORTS
// clk            in   1       controller clock (DDR user clock)
// rst_n          in   1       asynchronous active-low reset
// ddr_init_done  in   1       sync edges ignored while low
// vin_vs         in   1       writer frame sync, asynchronous to clk
// vout_vs        in   1       reader frame sync, asynchronous to clk
// rd_freeze      in   1       1: reader holds its current bank
// wr_bank        out  BANK_W  bank being written
// rd_bank        out  BANK_W  bank being read
// wr_load        out  1       1-cycle pulse, writer address restart
// rd_load        out  1       1-cycle pulse, reader address restart
// wr_drop        out  1       1-cycle pulse, unread completed frame superseded
// rd_repeat      out  1       1-cycle pulse, reader re-reads same bank
// frame_avail    out  1       a completed, unread frame is held
// BEHAVIOUR
// - Reset: wr_bank=0, rd_bank=1, all pulses 0, frame_avail=0, latest=0, armed=0, sync chains 0.
// - vs edge detect: SYNC_STAGES flops + 1 history flop; w_ev/r_ev = active edge, qualified by ddr_init_done.
// - Latency: vs transition to registered outputs = SYNC_STAGES+2 clk edges; all outputs registered.
// - Internal state: latest (bank of newest complete frame), frame_avail, armed.
// - Write event (w_ev):
//   - armed=0 (first after init): armed<=1, wr_load<=1, no frame completed, wr_bank unchanged.
//   - armed=1: completed frame = wr_bank; wr_drop<=frame_avail; latest_n=wr_bank; avail_n=1.
// - Read event (r_ev), evaluated after write-event update (latest_n/avail_n):
//   - avail_n=1 and rd_freeze=0: rd_bank<=latest_n, frame_avail<=0, rd_load<=1.
//   - else: rd_bank held, rd_load<=1, rd_repeat<=1.
// - Writer next bank (armed=1 write event): first bank b = wr_bank+k mod NUM_BANKS, k=1..NUM_BANKS-1, with
//   b != rd_bank_next (value after this cycle's read decision) and b != latest_n; wr_load<=1. Always exists for NUM_BANKS>=3.
// - Simultaneous w_ev/r_ev in one cycle: write first, reader may take just-completed bank; writer excludes new rd_bank.
// - Wrap: mod arithmetic on BANK_W bits, NUM_BANKS-1 -> 0.
// - Invariant: wr_bank != rd_bank whenever armed=1; assertion-checked in simulation.
// - ddr_init_done low: events ignored, armed<=0, banks and frame_avail held.
// - rst_n asserted mid-frame: immediate return to reset values; next write edge re-arms only.
// CONFIGURATION
// - FRAME_STATS_EN defined: adds outputs wr_frames[15:0], drop_cnt[15:0], repeat_cnt[15:0];
//   saturating at 16'hFFFF; incremented on armed write event / wr_drop / rd_repeat; reset to 0.
// - FRAME_STATS_EN undefined: those ports and counters are absent; remaining behaviour identical.
// TESTING
// - Reset, init_done=1, one vin edge -> wr_load pulse, wr_bank=0, frame_avail=0 (arming only).
// - NUM_BANKS=3: vin, vin, vout -> wr_bank 0->2, latest=0, rd_bank=0, rd_load=1, frame_avail=0.
// - Three vin edges, no vout -> second complete frame gives wr_drop=1; wr_bank never equals rd_bank.
// - vout with frame_avail=0 (or rd_freeze=1) -> rd_repeat=1, rd_load=1, rd_bank unchanged.
// - vin and vout edges in same clk, wr=2, rd=0 -> rd_bank=2, wr_bank=0 (first bank !=2, !=latest).
// - NUM_BANKS=5, 1000 random async vs edges, rst_n pulse mid-run -> invariant holds; counters match (FRAME_STATS_EN).

Source files
------------

// File: rtl/frame_bank_rotator_if.sv
// Frame-sync inputs and bank/pulse outputs of frame_bank_rotator; FRAME_STATS_EN adds the statistics counters.
// Latency: none, wiring only. Backpressure: none, every output is a level or a one-cycle pulse.
interface frame_bank_rotator_if #(
    parameter int BANK_W = 3
);
    logic              ddr_init_done;
    logic              vin_vs;
    logic              vout_vs;
    logic              rd_freeze;
    logic [BANK_W-1:0] wr_bank;
    logic [BANK_W-1:0] rd_bank;
    logic              wr_load;
    logic              rd_load;
    logic              wr_drop;
    logic              rd_repeat;
    logic              frame_avail;
`ifdef FRAME_STATS_EN
    logic [15:0]       wr_frames;
    logic [15:0]       drop_cnt;
    logic [15:0]       repeat_cnt;

    modport master (
        output ddr_init_done, vin_vs, vout_vs, rd_freeze,
        input  wr_bank, rd_bank, wr_load, rd_load, wr_drop, rd_repeat, frame_avail,
        input  wr_frames, drop_cnt, repeat_cnt
    );
    modport slave (
        input  ddr_init_done, vin_vs, vout_vs, rd_freeze,
        output wr_bank, rd_bank, wr_load, rd_load, wr_drop, rd_repeat, frame_avail,
        output wr_frames, drop_cnt, repeat_cnt
    );
`else
    modport master (
        output ddr_init_done, vin_vs, vout_vs, rd_freeze,
        input  wr_bank, rd_bank, wr_load, rd_load, wr_drop, rd_repeat, frame_avail
    );
    modport slave (
        input  ddr_init_done, vin_vs, vout_vs, rd_freeze,
        output wr_bank, rd_bank, wr_load, rd_load, wr_drop, rd_repeat, frame_avail
    );
`endif
endinterface

// File: rtl/frame_bank_rotator.sv
// N-bank frame-buffer rotator: writer/reader each own a DDR bank, handover at frame sync; FRAME_STATS_EN adds counters.
// Latency: vs transition to registered outputs = SYNC_STAGES+2 clk edges.
// Backpressure: none; rd_freeze holds the reader, superseded frames are flagged with wr_drop.
module frame_bank_rotator #(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit VS_POL      = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_bank_rotator_if.slave bus
);

    if (NUM_BANKS < 3 || NUM_BANKS > 8) begin : g_bad_banks
        $error("frame_bank_rotator: NUM_BANKS must be 3..8");
    end
    if (BANK_W < $clog2(NUM_BANKS) || $bits(bus.wr_bank) != BANK_W) begin : g_bad_width
        $error("frame_bank_rotator: BANK_W too small or not matching the interface");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("frame_bank_rotator: SYNC_STAGES must be 2..4");
    end

    logic [SYNC_STAGES-1:0] r_vin_sync, r_vout_sync;
    logic                   r_vin_hist, r_vout_hist;
    logic                   r_vin_edge, r_vout_edge;
    logic [BANK_W-1:0]      r_wr_bank, r_rd_bank, r_latest;
    logic                   r_frame_avail, r_armed;
    logic                   r_wr_load, r_rd_load, r_wr_drop, r_rd_repeat;

    logic                   w_vin_lvl, w_vout_lvl, w_vin_edge, w_vout_edge;
    logic                   w_ev, r_ev_q, w_done;
    logic [BANK_W-1:0]      w_latest_n, w_rd_next, w_wr_next, w_cand;
    logic                   w_avail_n, w_avail_next, w_repeat, w_found;

    assign w_vin_lvl   = r_vin_sync[SYNC_STAGES-1];
    assign w_vout_lvl  = r_vout_sync[SYNC_STAGES-1];
    assign w_vin_edge  = VS_POL ? (w_vin_lvl & ~r_vin_hist)   : (~w_vin_lvl & r_vin_hist);
    assign w_vout_edge = VS_POL ? (w_vout_lvl & ~r_vout_hist) : (~w_vout_lvl & r_vout_hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vin_sync  <= '0;
            r_vout_sync <= '0;
            r_vin_hist  <= 1'b0;
            r_vout_hist <= 1'b0;
            r_vin_edge  <= 1'b0;
            r_vout_edge <= 1'b0;
        end else begin
            r_vin_sync  <= {r_vin_sync[SYNC_STAGES-2:0], bus.vin_vs};
            r_vout_sync <= {r_vout_sync[SYNC_STAGES-2:0], bus.vout_vs};
            r_vin_hist  <= w_vin_lvl;
            r_vout_hist <= w_vout_lvl;
            r_vin_edge  <= w_vin_edge;
            r_vout_edge <= w_vout_edge;
        end
    end

    assign w_ev   = r_vin_edge & bus.ddr_init_done;
    assign r_ev_q = r_vout_edge & bus.ddr_init_done;
    assign w_done = w_ev & r_armed;

    // Write completion is resolved first so a simultaneous read can take the just-finished bank.
    always_comb begin
        w_latest_n   = r_latest;
        w_avail_n    = r_frame_avail;
        if (w_done) begin
            w_latest_n = r_wr_bank;
            w_avail_n  = 1'b1;
        end
        w_rd_next    = r_rd_bank;
        w_avail_next = w_avail_n;
        w_repeat     = 1'b0;
        if (r_ev_q) begin
            if (w_avail_n && !bus.rd_freeze) begin
                w_rd_next    = w_latest_n;
                w_avail_next = 1'b0;
            end else begin
                w_repeat = 1'b1;
            end
        end
        w_wr_next = r_wr_bank;
        w_cand    = r_wr_bank;
        w_found   = 1'b0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            w_cand = (w_cand == BANK_W'(NUM_BANKS - 1)) ? '0 : w_cand + BANK_W'(1);
            if (!w_found && w_cand != w_rd_next && w_cand != w_latest_n) begin
                w_wr_next = w_cand;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank     <= '0;
            r_rd_bank     <= BANK_W'(1);
            r_latest      <= '0;
            r_frame_avail <= 1'b0;
            r_armed       <= 1'b0;
            r_wr_load     <= 1'b0;
            r_rd_load     <= 1'b0;
            r_wr_drop     <= 1'b0;
            r_rd_repeat   <= 1'b0;
        end else begin
            r_wr_load     <= 1'b0;
            r_rd_load     <= 1'b0;
            r_wr_drop     <= 1'b0;
            r_rd_repeat   <= 1'b0;
            r_rd_bank     <= w_rd_next;
            r_latest      <= w_latest_n;
            r_frame_avail <= w_avail_next;
            if (!bus.ddr_init_done) begin
                r_armed <= 1'b0;
            end else if (w_ev && !r_armed) begin
                r_armed   <= 1'b1;
                r_wr_load <= 1'b1;
            end
            if (w_done) begin
                r_wr_load <= 1'b1;
                r_wr_drop <= r_frame_avail;
                r_wr_bank <= w_wr_next;
            end
            if (r_ev_q) begin
                r_rd_load   <= 1'b1;
                r_rd_repeat <= w_repeat;
            end
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0] r_wr_frames, r_drop_cnt, r_repeat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_frames  <= '0;
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else begin
            if (w_done && r_wr_frames != 16'hFFFF)
                r_wr_frames <= r_wr_frames + 16'd1;
            if (w_done && r_frame_avail && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (r_ev_q && w_repeat && r_repeat_cnt != 16'hFFFF)
                r_repeat_cnt <= r_repeat_cnt + 16'd1;
        end
    end

    assign bus.wr_frames  = r_wr_frames;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.repeat_cnt = r_repeat_cnt;
`endif

    assign bus.wr_bank     = r_wr_bank;
    assign bus.rd_bank     = r_rd_bank;
    assign bus.wr_load     = r_wr_load;
    assign bus.rd_load     = r_rd_load;
    assign bus.wr_drop     = r_wr_drop;
    assign bus.rd_repeat   = r_rd_repeat;
    assign bus.frame_avail = r_frame_avail;

    a_bank_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        r_armed |-> (r_wr_bank != r_rd_bank));

endmodule

// File: tb/tb_frame_bank_rotator.sv
// Bench for frame_bank_rotator: directed handover cases on a 3-bank instance, randomized sync edges on a 5-bank instance.
module tb_frame_bank_rotator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    frame_bank_rotator_if #(.BANK_W(3)) b3 ();
    frame_bank_rotator_if #(.BANK_W(3)) b5 ();

    frame_bank_rotator #(.NUM_BANKS(3), .BANK_W(3), .SYNC_STAGES(2), .VS_POL(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3));
    frame_bank_rotator #(.NUM_BANKS(5), .BANK_W(3), .SYNC_STAGES(3), .VS_POL(1'b1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .bus(b5));

    // {wr_bank, rd_bank, wr_load, rd_load, wr_drop, rd_repeat, frame_avail}
    function automatic logic [10:0] snap3();
        return {b3.wr_bank, b3.rd_bank, b3.wr_load, b3.rd_load, b3.wr_drop, b3.rd_repeat, b3.frame_avail};
    endfunction
    function automatic logic [10:0] snap5();
        return {b5.wr_bank, b5.rd_bank, b5.wr_load, b5.rd_load, b5.wr_drop, b5.rd_repeat, b5.frame_avail};
    endfunction

    // 3-bank instance: edge launched at a negedge shows up after SYNC_STAGES+2 = 4 posedges.
    task automatic fire3(input bit w, input bit r);
        @(negedge clk);
        b3.vin_vs  = w;
        b3.vout_vs = r;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic settle3();
        @(negedge clk);
        b3.vin_vs  = 1'b0;
        b3.vout_vs = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        b3.ddr_init_done = 1'b1; b3.vin_vs = 1'b0; b3.vout_vs = 1'b0; b3.rd_freeze = 1'b0;
        b5.ddr_init_done = 1'b1; b5.vin_vs = 1'b0; b5.vout_vs = 1'b0; b5.rd_freeze = 1'b0;
        do_reset();
        exp_v = {3'd0, 3'd1, 5'b00000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL reset3 got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        n_checks++;
        if (snap5() !== exp_v) $display("FAIL reset5 got=%b exp=%b", snap5(), exp_v);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_arm();
        logic [10:0] exp_v;
        @(negedge clk);
        b3.vin_vs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (b3.wr_load !== 1'b0) $display("FAIL arm_latency wr_load got=%b exp=0", b3.wr_load);
        else n_pass++;
        @(posedge clk);
        #1;
        exp_v = {3'd0, 3'd1, 5'b10000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL arm got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
    endtask

    task automatic test_first_frame();
        logic [10:0] exp_v;
        fire3(1'b1, 1'b0);
        exp_v = {3'd2, 3'd1, 5'b10001};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL first_write got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
        fire3(1'b0, 1'b1);
        exp_v = {3'd2, 3'd0, 5'b01000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL first_read got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
    endtask

    task automatic test_drop();
        logic [10:0] exp_q[$];
        exp_q = '{{3'd1, 3'd0, 5'b10001}, {3'd2, 3'd0, 5'b10101}, {3'd1, 3'd0, 5'b10101}};
        foreach (exp_q[i]) begin
            fire3(1'b1, 1'b0);
            n_checks++;
            if (snap3() !== exp_q[i]) $display("FAIL drop_%0d got=%b exp=%b", i, snap3(), exp_q[i]);
            else n_pass++;
            settle3();
        end
    endtask

    task automatic test_repeat();
        logic [10:0] exp_q[$];
        bit          frz_q[$];
        frz_q = '{1'b1, 1'b0, 1'b0};
        exp_q = '{{3'd1, 3'd0, 5'b01011}, {3'd1, 3'd2, 5'b01000}, {3'd1, 3'd2, 5'b01010}};
        foreach (exp_q[i]) begin
            @(negedge clk);
            b3.rd_freeze = frz_q[i];
            fire3(1'b0, 1'b1);
            n_checks++;
            if (snap3() !== exp_q[i]) $display("FAIL repeat_%0d got=%b exp=%b", i, snap3(), exp_q[i]);
            else n_pass++;
            settle3();
        end
        b3.rd_freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_v;
        do_reset();
        release_reset();
        fire3(1'b1, 1'b0); settle3();
        fire3(1'b1, 1'b0); settle3();
        fire3(1'b0, 1'b1); settle3();
        fire3(1'b1, 1'b1);
        exp_v = {3'd0, 3'd2, 5'b11000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL simultaneous got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
    endtask

    task automatic test_init_done();
        logic [10:0] exp_v;
        @(negedge clk);
        b3.ddr_init_done = 1'b0;
        fire3(1'b1, 1'b1);
        exp_v = {3'd0, 3'd2, 5'b00000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL init_low got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
        b3.ddr_init_done = 1'b1;
        fire3(1'b1, 1'b0);
        exp_v = {3'd0, 3'd2, 5'b10000};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL rearm got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
        fire3(1'b1, 1'b0);
        exp_v = {3'd1, 3'd2, 5'b10001};
        n_checks++;
        if (snap3() !== exp_v) $display("FAIL after_rearm got=%b exp=%b", snap3(), exp_v);
        else n_pass++;
        settle3();
    endtask

    // Reference state for the 5-bank instance, advanced one frame event at a time.
    int m_wr, m_rd, m_latest;
    bit m_avail, m_armed;
    bit e_wl, e_rl, e_dr, e_rp;
    int m_frames, m_drops, m_repeats;

    function automatic void model_reset();
        m_wr = 0; m_rd = 1; m_latest = 0; m_avail = 0; m_armed = 0;
        e_wl = 0; e_rl = 0; e_dr = 0; e_rp = 0;
        m_frames = 0; m_drops = 0; m_repeats = 0;
    endfunction

    function automatic void model_apply(input bit we, input bit re, input bit frz);
        int  latest_n, rd_n;
        bit  avail_n, done, found;
        e_wl = 0; e_rl = 0; e_dr = 0; e_rp = 0;
        latest_n = m_latest; avail_n = m_avail; done = 0;
        if (we) begin
            e_wl = 1;
            if (!m_armed) m_armed = 1;
            else begin
                done = 1;
                e_dr = m_avail;
                latest_n = m_wr;
                avail_n = 1;
            end
        end
        rd_n = m_rd;
        if (re) begin
            e_rl = 1;
            if (avail_n && !frz) begin
                rd_n = latest_n;
                avail_n = 0;
            end else e_rp = 1;
        end
        if (done) begin
            found = 0;
            for (int k = 1; k < 5; k++) begin
                if (!found && ((m_wr + k) % 5) != rd_n && ((m_wr + k) % 5) != latest_n) begin
                    m_wr = (m_wr + k) % 5;
                    found = 1;
                end
            end
            m_frames++;
        end
        if (e_dr) m_drops++;
        if (e_rp) m_repeats++;
        m_rd = rd_n; m_latest = latest_n; m_avail = avail_n;
    endfunction

    task automatic test_random();
        bit          qw[$], qr[$];
        bit          prev_w, prev_r, frz_prev, we, re, vin_n, vout_n;
        int          in_rst;
        logic [10:0] exp_v;
        model_reset();
        qw = {}; qr = {};
        repeat (5) begin qw.push_back(1'b0); qr.push_back(1'b0); end
        prev_w = 0; prev_r = 0; frz_prev = 0;
        @(negedge clk);
        rst_n = 1'b0;
        b5.vin_vs = 1'b0; b5.vout_vs = 1'b0; b5.rd_freeze = 1'b0;
        in_rst = 3;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            we = qw.pop_front();
            re = qr.pop_front();
            if (!rst_n) model_reset();
            else model_apply(we, re, frz_prev);
            exp_v = {3'(m_wr), 3'(m_rd), e_wl, e_rl, e_dr, e_rp, m_avail};
            n_checks++;
            if (snap5() !== exp_v) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, snap5(), exp_v);
            else n_pass++;
            if (m_armed) begin
                n_checks++;
                if (b5.wr_bank === b5.rd_bank)
                    $display("FAIL invariant cyc=%0d wr=%0d rd=%0d must differ", cyc, b5.wr_bank, b5.rd_bank);
                else n_pass++;
            end
            #($urandom_range(0, 3));
            if (cyc == 3000) begin
                rst_n = 1'b0;
                model_reset();
                qw = {}; qr = {};
                repeat (4) begin qw.push_back(1'b0); qr.push_back(1'b0); end
                in_rst = 3;
            end
            vin_n  = b5.vin_vs;
            vout_n = b5.vout_vs;
            if (cyc < 5970 && in_rst == 0) begin
                vin_n  = vin_n ^ ($urandom_range(0, 3) == 0);
                vout_n = vout_n ^ ($urandom_range(0, 3) == 0);
            end
            b5.vin_vs    = vin_n;
            b5.vout_vs   = vout_n;
            frz_prev     = ($urandom_range(0, 4) == 0);
            b5.rd_freeze = frz_prev;
            if (in_rst > 0) begin
                in_rst--;
                if (in_rst == 0) rst_n = 1'b1;
            end
            if (rst_n) begin
                qw.push_back(vin_n & !prev_w);
                qr.push_back(vout_n & !prev_r);
                prev_w = vin_n;
                prev_r = vout_n;
            end else begin
                qw.push_back(1'b0);
                qr.push_back(1'b0);
                prev_w = 0;
                prev_r = 0;
            end
        end
`ifdef FRAME_STATS_EN
        n_checks++;
        if (b5.wr_frames !== 16'(m_frames)) $display("FAIL wr_frames got=%0d exp=%0d", b5.wr_frames, m_frames);
        else n_pass++;
        n_checks++;
        if (b5.drop_cnt !== 16'(m_drops)) $display("FAIL drop_cnt got=%0d exp=%0d", b5.drop_cnt, m_drops);
        else n_pass++;
        n_checks++;
        if (b5.repeat_cnt !== 16'(m_repeats)) $display("FAIL repeat_cnt got=%0d exp=%0d", b5.repeat_cnt, m_repeats);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_arm();
        test_first_frame();
        test_drop();
        test_repeat();
        test_back_to_back();
        test_init_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
